bintobcd: RTL and testbench

BINTOBCD -- requirements
Module: bintobcd

---
 rtl/bintobcd_pkg.sv | 16 +
 rtl/bcd_add3.sv | 16 +
 rtl/bintobcd.sv | 112 +++++++++++
 tb/tb_bintobcd.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bintobcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter: display nibble
// codes, FSM state encoding and the double-dabble shift count.
package bintobcd_pkg;

   localparam logic [3:0]  BLANK_DEF   = 4'b1111;
   localparam logic [3:0]  NEGC_DEF    = 4'b1110;
   localparam int unsigned SHIFT_COUNT = 11;
   localparam int unsigned BIN_W       = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FMT   = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // add-3 correction for digits >= 5
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end
   end

endmodule

// File: rtl/bintobcd.sv
// Signed 11-bit binary to 4-digit display word converter. A sequential
// double-dabble runs one bit per cycle; the result is then formatted with
// leading-zero blanking, a minus-sign nibble and an overflow indication.
module bintobcd
   import bintobcd_pkg::*;
#(
   parameter logic [3:0] BLANK = BLANK_DEF,
   parameter logic [3:0] NEGC  = NEGC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] binin,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [31:0] BCD
);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [BIN_W-1:0]  r_mag;
   logic              r_sign;
   logic [15:0]       r_acc;
   logic [15:0]       w_corr;
   logic              w_ovf;
   logic [3:0]        w_sign_n;
   logic [3:0]        w_hund_n;
   logic [3:0]        w_tens_n;
   logic [31:0]       w_fmt;

   // one add-3 corrector per digit (ones, tens, hundreds, thousands)
   for (genvar g = 0; g < 4; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit(r_acc[4*g +: 4]),
         .o_digit(w_corr[4*g +: 4])
      );
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == 4'(SHIFT_COUNT - 1)) w_next = ST_FMT;
         ST_FMT:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (r_state == ST_SHIFT) || (r_state == ST_FMT);
   end

   // result formatting; a nonzero thousands digit means |value| > 999
   always_comb begin
      w_ovf    = (r_acc[15:12] != 4'd0);
      w_sign_n = (r_sign && (r_acc != '0)) ? NEGC : BLANK;
      w_hund_n = (r_acc[11:8] == 4'd0) ? BLANK : r_acc[11:8];
      w_tens_n = (r_acc[11:4] == 8'd0) ? BLANK : r_acc[7:4];
      w_fmt    = w_ovf ? '1 : {BLANK, BLANK, BLANK, BLANK,
                               w_sign_n, w_hund_n, w_tens_n, r_acc[3:0]};
   end

   // datapath: capture, shift-and-correct, and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_mag  <= '0;
         r_sign <= 1'b0;
         r_acc  <= '0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         BCD    <= '1;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sign <= binin[10];
                  r_mag  <= binin[10] ? (~binin + 11'd1) : binin;
                  r_acc  <= '0;
                  r_cnt  <= '0;
               end
            end
            ST_SHIFT: begin
               r_acc <= {w_corr[14:0], r_mag[BIN_W-1]};
               r_mag <= {r_mag[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
            end
            ST_FMT: begin
               done <= 1'b1;
               ovf  <= w_ovf;
               BCD  <= w_fmt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bintobcd.sv
// Scoreboard bench for bintobcd: stimulus pushes expected results with the
// cycle on which done must appear; a monitor pops and compares on each done.
module tb_bintobcd;

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
      int          due;
   } exp_t;

   typedef struct {
      int          val;
      logic [31:0] bcd;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] binin = '0;
   logic        busy, done, ovf;
   logic [31:0] BCD;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_done = -1;
   logic prev_done = 1'b0;
   exp_t sb[$];

   bintobcd #(.BLANK(4'b1111), .NEGC(4'b1110)) dut (
      .clk(clk), .rst(rst), .start(start), .binin(binin),
      .busy(busy), .done(done), .ovf(ovf), .BCD(BCD)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every done must match the oldest expectation, on its due cycle
   always @(negedge clk) begin
      if (!rst && done) begin
         check("done_single_pulse", 32'(prev_done), 32'd0);
         check("busy_low_on_done", 32'(busy), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("bcd", BCD, e.bcd);
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("latency", 32'(cyc), 32'(e.due));
         end
         last_done = cyc;
      end
      prev_done = done;
   end

   // drive one start; done is due on the 12th edge after the accepting edge
   task automatic issue(input int val, input logic [31:0] ebcd, input logic eovf);
      exp_t e;
      @(negedge clk);
      binin = 11'(val);
      start = 1'b1;
      @(posedge clk);
      #1;
      e.bcd = ebcd; e.ovf = eovf; e.due = cyc + 12;
      sb.push_back(e);
      check("busy_after_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      binin = 11'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("timeout", 32'd1, 32'd0);
      @(negedge clk);
      check("busy_low_after", 32'(busy), 32'd0);
   endtask

   vec_t vecs[$] = '{
      '{0,     32'hFFFF_FFF0, 1'b0},
      '{123,   32'hFFFF_F123, 1'b0},
      '{105,   32'hFFFF_F105, 1'b0},
      '{7,     32'hFFFF_FFF7, 1'b0},
      '{-45,   32'hFFFF_EF45, 1'b0},
      '{-999,  32'hFFFF_E999, 1'b0},
      '{999,   32'hFFFF_F999, 1'b0},
      '{1000,  32'hFFFF_FFFF, 1'b1},
      '{1023,  32'hFFFF_FFFF, 1'b1},
      '{-1024, 32'hFFFF_FFFF, 1'b1},
      '{5,     32'hFFFF_FFF5, 1'b0},
      '{-1,    32'hFFFF_EFF1, 1'b0},
      '{10,    32'hFFFF_FF10, 1'b0},
      '{-100,  32'hFFFF_E100, 1'b0},
      '{90,    32'hFFFF_FF90, 1'b0}
   };

   initial begin
      int first_done;
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_bcd", BCD, 32'hFFFF_FFFF);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         issue(vecs[i].val, vecs[i].bcd, vecs[i].ovf);
         wait_idle();
         check("bcd_hold", BCD, vecs[i].bcd);
      end

      // start pulsed 4 cycles into a conversion must be ignored
      issue(123, 32'hFFFF_F123, 1'b0);
      repeat (2) @(negedge clk);
      binin = 11'd456;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);

      // start held on the done cycle: second done 13 edges after the first
      issue(7, 32'hFFFF_FFF7, 1'b0);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("timeout_b2b", 32'd1, 32'd0);
      first_done = cyc;
      binin = 11'd456;
      start = 1'b1;
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.bcd = 32'hFFFF_F456; e.ovf = 1'b0; e.due = first_done + 13;
         sb.push_back(e);
      end
      check("b2b_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("b2b_spacing", 32'(last_done - first_done), 32'd13);

      // reset in the middle of SHIFT aborts without a done
      issue(-300, 32'hFFFF_E300, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      check("abort_bcd", BCD, 32'hFFFF_FFFF);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      issue(-8, 32'hFFFF_EFF8, 1'b0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
